// File: rtl/writeback_stage.sv
// Writeback stage: two fixed-depth result pipes feeding the register file,
// with same-RT odd-issue stall and youngest-ready forwarding.
module writeback_stage #(
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W+14:0] ep_in_packet,
    input  logic [DATA_W+14:0] op_in_packet,
    input  logic              flush,
    input  logic [6:0]        fwd_addr_ep,
    input  logic [6:0]        fwd_addr_op,
    output logic [DATA_W+14:0] wrt_back_arr_ep,
    output logic [DATA_W+14:0] wrt_back_arr_op,
    output logic              wrt_en_ep,
    output logic              wrt_en_op,
    output logic [6:0]        rt_ep_address,
    output logic [6:0]        rt_op_address,
    output logic              fwd_hit_ep,
    output logic              fwd_hit_op,
    output logic [DATA_W-1:0] fwd_value_ep,
    output logic [DATA_W-1:0] fwd_value_op,
    output logic              stall_odd
);

    localparam int PW    = DATA_W + 15;
    localparam int V_LO  = 3;
    localparam int V_HI  = DATA_W + 2;
    localparam int WR    = DATA_W + 3;
    localparam int RT_LO = DATA_W + 4;
    localparam int RT_HI = DATA_W + 10;
    localparam int L_LO  = DATA_W + 11;
    localparam int L_HI  = DATA_W + 13;
    localparam int VLD   = DATA_W + 14;

    logic [PW-1:0] ep_pipe [DEPTH];
    logic [PW-1:0] op_pipe [DEPTH];

    function automatic logic [6:0] pkt_rt(input logic [PW-1:0] p);
        return p[RT_HI:RT_LO];
    endfunction

    function automatic logic [DATA_W-1:0] pkt_val(input logic [PW-1:0] p);
        return p[V_HI:V_LO];
    endfunction

    function automatic logic pkt_writes(input logic [PW-1:0] p);
        return p[VLD] & p[WR];
    endfunction

    // A latency of zero behaves like a single-cycle unit.
    function automatic logic pkt_ready(
        input logic [PW-1:0] p,
        input int            stage
    );
        logic [2:0] lat;
        lat = p[L_HI:L_LO];
        if (lat == 3'd0) begin
            lat = 3'd1;
        end
        return stage >= int'(lat);
    endfunction

    function automatic logic fwd_match(
        input logic [PW-1:0] p,
        input int            stage,
        input logic [6:0]    addr
    );
        return pkt_writes(p) && (pkt_rt(p) == addr) && pkt_ready(p, stage);
    endfunction

    always_comb begin
        stall_odd = pkt_writes(ep_in_packet) &&
                    pkt_writes(op_in_packet) &&
                    (pkt_rt(ep_in_packet) == pkt_rt(op_in_packet));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ep_pipe[i] <= '0;
                op_pipe[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ep_pipe[i] <= '0;
                op_pipe[i] <= '0;
            end
        end else begin
            ep_pipe[0] <= ep_in_packet[VLD] ? ep_in_packet : '0;
            op_pipe[0] <= (op_in_packet[VLD] && !stall_odd) ? op_in_packet : '0;
            for (int i = 1; i < DEPTH; i++) begin
                ep_pipe[i] <= ep_pipe[i-1];
                op_pipe[i] <= op_pipe[i-1];
            end
        end
    end

    always_comb begin
        wrt_back_arr_ep = ep_pipe[DEPTH-1];
        wrt_back_arr_op = op_pipe[DEPTH-1];
        wrt_en_ep       = pkt_writes(ep_pipe[DEPTH-1]);
        wrt_en_op       = pkt_writes(op_pipe[DEPTH-1]);
        rt_ep_address   = pkt_rt(ep_pipe[DEPTH-1]);
        rt_op_address   = pkt_rt(op_pipe[DEPTH-1]);
    end

    // Oldest-first scan so younger stages overwrite; even checked last wins ties.
    always_comb begin
        fwd_hit_ep   = 1'b0;
        fwd_hit_op   = 1'b0;
        fwd_value_ep = '0;
        fwd_value_op = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (fwd_match(op_pipe[i], i + 1, fwd_addr_ep)) begin
                fwd_hit_ep   = 1'b1;
                fwd_value_ep = pkt_val(op_pipe[i]);
            end
            if (fwd_match(ep_pipe[i], i + 1, fwd_addr_ep)) begin
                fwd_hit_ep   = 1'b1;
                fwd_value_ep = pkt_val(ep_pipe[i]);
            end
            if (fwd_match(op_pipe[i], i + 1, fwd_addr_op)) begin
                fwd_hit_op   = 1'b1;
                fwd_value_op = pkt_val(op_pipe[i]);
            end
            if (fwd_match(ep_pipe[i], i + 1, fwd_addr_op)) begin
                fwd_hit_op   = 1'b1;
                fwd_value_op = pkt_val(ep_pipe[i]);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus
// hand-written forwarding, flush and reset sequences.
module tb_writeback_stage;

    logic         clock = 1'b0;
    logic         reset;
    logic [142:0] ep_in_packet;
    logic [142:0] op_in_packet;
    logic         flush;
    logic [6:0]   fwd_addr_ep;
    logic [6:0]   fwd_addr_op;
    logic [142:0] wrt_back_arr_ep;
    logic [142:0] wrt_back_arr_op;
    logic         wrt_en_ep;
    logic         wrt_en_op;
    logic [6:0]   rt_ep_address;
    logic [6:0]   rt_op_address;
    logic         fwd_hit_ep;
    logic         fwd_hit_op;
    logic [127:0] fwd_value_ep;
    logic [127:0] fwd_value_op;
    logic         stall_odd;

    int checks = 0;
    int errors = 0;

    writeback_stage dut (
        .clock           (clock),
        .reset           (reset),
        .ep_in_packet    (ep_in_packet),
        .op_in_packet    (op_in_packet),
        .flush           (flush),
        .fwd_addr_ep     (fwd_addr_ep),
        .fwd_addr_op     (fwd_addr_op),
        .wrt_back_arr_ep (wrt_back_arr_ep),
        .wrt_back_arr_op (wrt_back_arr_op),
        .wrt_en_ep       (wrt_en_ep),
        .wrt_en_op       (wrt_en_op),
        .rt_ep_address   (rt_ep_address),
        .rt_op_address   (rt_op_address),
        .fwd_hit_ep      (fwd_hit_ep),
        .fwd_hit_op      (fwd_hit_op),
        .fwd_value_ep    (fwd_value_ep),
        .fwd_value_op    (fwd_value_op),
        .stall_odd       (stall_odd)
    );

    always #5 clock = ~clock;

    localparam logic [127:0] VAL_1S = {16{8'h11}};
    localparam logic [127:0] VA     = {4{32'hAAAA0001}};
    localparam logic [127:0] VB     = {4{32'hBBBB0002}};
    localparam logic [127:0] VC     = {4{32'hCCCC0003}};
    localparam logic [127:0] VD     = {4{32'hDDDD0004}};

    typedef struct {
        logic [142:0] ep;
        logic [142:0] op;
        logic         stall;
        logic         wep;
        logic         wop;
        logic         fhit;
    } vec_t;

    vec_t tv [7];

    function automatic logic [142:0] mk(
        input logic         v,
        input logic         w,
        input logic [6:0]   rt,
        input logic [2:0]   l,
        input logic [127:0] val,
        input logic [2:0]   uid
    );
        return {v, l, rt, w, val, uid};
    endfunction

    task automatic check(
        input string        name,
        input logic [142:0] act,
        input logic [142:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ep_in_packet = '0;
        op_in_packet = '0;
        flush        = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " wrt_en_ep"}, wrt_en_ep, 1'b0);
        check({tag, " wrt_en_op"}, wrt_en_op, 1'b0);
    endtask

    logic [142:0] exp_ep;
    logic [142:0] exp_op;

    initial begin
        tv[0] = '{ep: mk(1, 1, 7'd5, 3'd3, {4{32'h00000010}}, 3'd1),
                  op: '0, stall: 0, wep: 1, wop: 0, fhit: 1};
        tv[1] = '{ep: mk(1, 1, 7'd9, 3'd7, {4{32'h00000011}}, 3'd2),
                  op: mk(1, 1, 7'd9, 3'd4, {4{32'h00000012}}, 3'd3),
                  stall: 1, wep: 1, wop: 0, fhit: 1};
        tv[2] = '{ep: mk(1, 1, 7'd9, 3'd1, {4{32'h00000013}}, 3'd4),
                  op: mk(1, 1, 7'd10, 3'd2, {4{32'h00000014}}, 3'd5),
                  stall: 0, wep: 1, wop: 1, fhit: 1};
        tv[3] = '{ep: mk(1, 0, 7'd9, 3'd2, {4{32'h00000015}}, 3'd6),
                  op: mk(1, 1, 7'd12, 3'd3, {4{32'h00000016}}, 3'd7),
                  stall: 0, wep: 0, wop: 1, fhit: 0};
        tv[4] = '{ep: mk(0, 1, 7'd9, 3'd2, {4{32'h00000017}}, 3'd1),
                  op: mk(1, 1, 7'd9, 3'd5, {4{32'h00000018}}, 3'd2),
                  stall: 0, wep: 0, wop: 1, fhit: 1};
        tv[5] = '{ep: mk(1, 1, 7'd127, 3'd0, {4{32'h00000019}}, 3'd0),
                  op: mk(1, 1, 7'd127, 3'd0, {4{32'h0000001A}}, 3'd0),
                  stall: 1, wep: 1, wop: 0, fhit: 1};
        tv[6] = '{ep: mk(1, 1, 7'd20, 3'd2, {4{32'h0000001B}}, 3'd3),
                  op: mk(1, 0, 7'd20, 3'd2, {4{32'h0000001C}}, 3'd4),
                  stall: 0, wep: 1, wop: 0, fhit: 1};

        reset       = 1'b0;
        fwd_addr_ep = 7'd0;
        fwd_addr_op = 7'd0;
        idle();
        #1;
        check("reset wrt_back_arr_ep", wrt_back_arr_ep, '0);
        check("reset wrt_back_arr_op", wrt_back_arr_op, '0);
        check_quiet("reset");
        check("reset fwd_hit_ep", fwd_hit_ep, 1'b0);
        check("reset fwd_value_ep", fwd_value_ep, '0);

        // stall_odd stays combinational while reset is held
        for (int i = 0; i < 7; i++) begin
            ep_in_packet = tv[i].ep;
            op_in_packet = tv[i].op;
            fwd_addr_ep  = tv[i].ep[138:132];
            #1;
            check($sformatf("rst stall_odd v%0d", i), stall_odd, tv[i].stall);
            check($sformatf("rst fwd_hit_ep v%0d", i), fwd_hit_ep, 1'b0);
            check_quiet($sformatf("rst v%0d", i));
        end
        idle();
        step();
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            idle();
            ep_in_packet = tv[i].ep;
            op_in_packet = tv[i].op;
            fwd_addr_ep  = tv[i].ep[138:132];
            fwd_addr_op  = 7'd0;
            #1;
            check($sformatf("stall_odd v%0d", i), stall_odd, tv[i].stall);
            step();
            idle();
            for (int c = 1; c <= 6; c++) begin
                #1;
                check_quiet($sformatf("v%0d c%0d", i, c));
                step();
            end
            #1;
            exp_ep = tv[i].ep[142] ? tv[i].ep : '0;
            exp_op = (tv[i].op[142] && !tv[i].stall) ? tv[i].op : '0;
            check($sformatf("wrt_en_ep v%0d", i), wrt_en_ep, tv[i].wep);
            check($sformatf("wrt_en_op v%0d", i), wrt_en_op, tv[i].wop);
            check($sformatf("wrt_back_arr_ep v%0d", i), wrt_back_arr_ep, exp_ep);
            check($sformatf("wrt_back_arr_op v%0d", i), wrt_back_arr_op, exp_op);
            check($sformatf("rt_ep_address v%0d", i), rt_ep_address, exp_ep[138:132]);
            check($sformatf("rt_op_address v%0d", i), rt_op_address, exp_op[138:132]);
            check($sformatf("fwd_hit_ep v%0d", i), fwd_hit_ep, tv[i].fhit);
        end
        idle();
        step();
        step();

        // single even packet: forwarding from stage 2, write in cycle 7
        fwd_addr_ep  = 7'd5;
        fwd_addr_op  = 7'd5;
        ep_in_packet = mk(1, 1, 7'd5, 3'd2, VAL_1S, 3'd1);
        step();
        idle();
        for (int c = 1; c <= 8; c++) begin
            #1;
            check($sformatf("A fwd_hit_ep c%0d", c), fwd_hit_ep, c >= 2 && c <= 7);
            check($sformatf("A fwd_value_op c%0d", c), fwd_value_op,
                  (c >= 2 && c <= 7) ? VAL_1S : 128'h0);
            check($sformatf("A wrt_en_ep c%0d", c), wrt_en_ep, c == 7);
            check($sformatf("A wrt_en_op c%0d", c), wrt_en_op, 1'b0);
            if (c == 7) begin
                check("A rt_ep_address", rt_ep_address, 7'd5);
            end
            step();
        end

        // odd slow unit then younger fast even unit on the same RT
        fwd_addr_ep  = 7'd3;
        fwd_addr_op  = 7'd3;
        op_in_packet = mk(1, 1, 7'd3, 3'd6, VA, 3'd1);
        step();
        idle();
        ep_in_packet = mk(1, 1, 7'd3, 3'd1, VB, 3'd2);
        for (int c = 1; c <= 9; c++) begin
            #1;
            check($sformatf("B1 fwd_hit_op c%0d", c), fwd_hit_op, c >= 2 && c <= 8);
            check($sformatf("B1 fwd_value_ep c%0d", c), fwd_value_ep,
                  (c >= 2 && c <= 8) ? VB : 128'h0);
            check($sformatf("B1 wrt_en_op c%0d", c), wrt_en_op, c == 7);
            check($sformatf("B1 wrt_en_ep c%0d", c), wrt_en_ep, c == 8);
            step();
            idle();
        end

        // older ready even result wins until the younger odd one is ready
        fwd_addr_ep  = 7'd4;
        fwd_addr_op  = 7'd4;
        ep_in_packet = mk(1, 1, 7'd4, 3'd1, VC, 3'd3);
        step();
        idle();
        op_in_packet = mk(1, 1, 7'd4, 3'd5, VD, 3'd4);
        for (int c = 1; c <= 9; c++) begin
            #1;
            check($sformatf("B2 fwd_hit_ep c%0d", c), fwd_hit_ep, c <= 8);
            check($sformatf("B2 fwd_value_op c%0d", c), fwd_value_op,
                  (c <= 5) ? VC : (c <= 8) ? VD : 128'h0);
            step();
            idle();
        end

        // flush with three packets in flight plus one presented
        fwd_addr_ep  = 7'd1;
        fwd_addr_op  = 7'd3;
        ep_in_packet = mk(1, 1, 7'd1, 3'd1, VA, 3'd1);
        step();
        ep_in_packet = mk(1, 1, 7'd2, 3'd1, VB, 3'd2);
        op_in_packet = mk(1, 1, 7'd3, 3'd1, VC, 3'd3);
        step();
        idle();
        step();
        step();
        check("C pre-flush fwd_hit_ep", fwd_hit_ep, 1'b1);
        check("C pre-flush fwd_hit_op", fwd_hit_op, 1'b1);
        flush        = 1'b1;
        ep_in_packet = mk(1, 1, 7'd6, 3'd1, VD, 3'd4);
        op_in_packet = mk(1, 1, 7'd6, 3'd1, VD, 3'd5);
        #1;
        check("C flush stall_odd", stall_odd, 1'b1);
        step();
        idle();
        fwd_addr_op = 7'd6;
        for (int c = 5; c <= 13; c++) begin
            #1;
            check_quiet($sformatf("C c%0d", c));
            check($sformatf("C fwd_hit_ep c%0d", c), fwd_hit_ep, 1'b0);
            check($sformatf("C fwd_hit_op c%0d", c), fwd_hit_op, 1'b0);
            step();
        end

        // reset asserted with packets in flight
        fwd_addr_ep  = 7'd7;
        fwd_addr_op  = 7'd8;
        ep_in_packet = mk(1, 1, 7'd7, 3'd1, VA, 3'd1);
        op_in_packet = mk(1, 1, 7'd8, 3'd1, VB, 3'd2);
        step();
        ep_in_packet = mk(1, 1, 7'd9, 3'd1, VC, 3'd3);
        op_in_packet = '0;
        step();
        idle();
        step();
        check("D pre-reset fwd_hit_ep", fwd_hit_ep, 1'b1);
        reset        = 1'b0;
        ep_in_packet = mk(1, 1, 7'd11, 3'd2, VD, 3'd1);
        op_in_packet = mk(1, 1, 7'd11, 3'd2, VD, 3'd2);
        #1;
        check("D rst fwd_hit_ep", fwd_hit_ep, 1'b0);
        check("D rst fwd_hit_op", fwd_hit_op, 1'b0);
        check("D rst fwd_value_ep", fwd_value_ep, '0);
        check("D rst wrt_back_arr_ep", wrt_back_arr_ep, '0);
        check("D rst stall_odd", stall_odd, 1'b1);
        step();
        check_quiet("D rst c4");
        step();
        reset = 1'b1;
        idle();
        for (int c = 5; c <= 14; c++) begin
            #1;
            check_quiet($sformatf("D c%0d", c));
            check($sformatf("D fwd_hit_ep c%0d", c), fwd_hit_ep, 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
